// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP-1 controller-sequencer.
// Opcodes, control-word bit positions, one-hot T-states and the
// micro-op words that the decoder ROM emits.
package sap_pkg;

  typedef logic [3:0]  opcode_t;
  typedef logic [5:0]  tstate_t;
  typedef logic [11:0] con_t;

  // Opcodes (upper nibble of the instruction register)
  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  // Control-word bit indices, MSB first; *_N bits are active-low
  localparam int CON_CP   = 11;
  localparam int CON_EP   = 10;
  localparam int CON_LM_N = 9;
  localparam int CON_CE_N = 8;
  localparam int CON_LI_N = 7;
  localparam int CON_EI_N = 6;
  localparam int CON_LA_N = 5;
  localparam int CON_EA   = 4;
  localparam int CON_SU   = 3;
  localparam int CON_EU   = 2;
  localparam int CON_LB_N = 1;
  localparam int CON_LO_N = 0;

  // One-hot T-states as produced by the ring counter
  localparam tstate_t T1 = 6'b100000;
  localparam tstate_t T2 = 6'b010000;
  localparam tstate_t T3 = 6'b001000;
  localparam tstate_t T4 = 6'b000100;
  localparam tstate_t T5 = 6'b000010;
  localparam tstate_t T6 = 6'b000001;

  // Single-bit masks used to compose the micro-op words below
  localparam con_t B_CP   = con_t'(1) << CON_CP;
  localparam con_t B_EP   = con_t'(1) << CON_EP;
  localparam con_t B_LM_N = con_t'(1) << CON_LM_N;
  localparam con_t B_CE_N = con_t'(1) << CON_CE_N;
  localparam con_t B_LI_N = con_t'(1) << CON_LI_N;
  localparam con_t B_EI_N = con_t'(1) << CON_EI_N;
  localparam con_t B_LA_N = con_t'(1) << CON_LA_N;
  localparam con_t B_EA   = con_t'(1) << CON_EA;
  localparam con_t B_SU   = con_t'(1) << CON_SU;
  localparam con_t B_EU   = con_t'(1) << CON_EU;
  localparam con_t B_LB_N = con_t'(1) << CON_LB_N;
  localparam con_t B_LO_N = con_t'(1) << CON_LO_N;

  // Everything inactive: active-low strobes high, active-high strobes low (0x3E3)
  localparam con_t NOP_CON = B_LM_N | B_CE_N | B_LI_N | B_EI_N | B_LA_N | B_LB_N | B_LO_N;

  // Fetch: PC -> MAR, increment PC, RAM -> IR
  localparam con_t FETCH_T1 = (NOP_CON | B_EP) & ~B_LM_N;           // 0x5E3
  localparam con_t FETCH_T2 =  NOP_CON | B_CP;                      // 0xBE3
  localparam con_t FETCH_T3 =  NOP_CON & ~(B_CE_N | B_LI_N);        // 0x263

  // Execute words
  localparam con_t LDA_T4 = NOP_CON & ~(B_LM_N | B_EI_N);           // 0x1A3 IR addr -> MAR
  localparam con_t LDA_T5 = NOP_CON & ~(B_CE_N | B_LA_N);           // 0x2C3 RAM -> A
  localparam con_t ADD_T5 = NOP_CON & ~(B_CE_N | B_LB_N);           // 0x2E1 RAM -> B
  localparam con_t ADD_T6 = (NOP_CON | B_EU) & ~B_LA_N;             // 0x3C7 A+B -> A
  localparam con_t SUB_T6 = (NOP_CON | B_EU | B_SU) & ~B_LA_N;      // 0x3CF A-B -> A
  localparam con_t OUT_T4 = (NOP_CON | B_EA) & ~B_LO_N;             // 0x3F2 A -> OUT

  // True when exactly one bit of the T-state vector is set
  function automatic logic is_one_hot(tstate_t t);
    return (t != '0) && ((t & (t - tstate_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/sap_con_decode.sv
// sap_con_decode: combinational micro-op ROM mapping (T-state, latched
// opcode) to the 12-bit control word. Non-one-hot T-states and unknown
// opcodes decode to the inactive word.
module sap_con_decode
  import sap_pkg::*;
(
  input  logic [5:0]  t_i,
  input  logic [3:0]  op_i,
  output logic [11:0] con_o
);

  // ROM lookup: fetch words are opcode-independent, execute words use op_i
  always_comb begin
    // NOTE: default assignment first so every path drives con_o and no latch is inferred.
    con_o = NOP_CON;
    case (t_i)
      T1: con_o = FETCH_T1;
      T2: con_o = FETCH_T2;
      T3: con_o = FETCH_T3;
      T4: begin
        case (op_i)
          OP_LDA, OP_ADD, OP_SUB: con_o = LDA_T4;
          OP_OUT:                 con_o = OUT_T4;
          default:                con_o = NOP_CON;
        endcase
      end
      T5: begin
        case (op_i)
          OP_LDA:         con_o = LDA_T5;
          OP_ADD, OP_SUB: con_o = ADD_T5;
          default:        con_o = NOP_CON;
        endcase
      end
      T6: begin
        case (op_i)
          OP_ADD:  con_o = ADD_T6;
          OP_SUB:  con_o = SUB_T6;
          default: con_o = NOP_CON;
        endcase
      end
      default: con_o = NOP_CON;
    endcase
  end

endmodule

// File: rtl/sap_controller.sv
// sap_controller: SAP-1 controller-sequencer. Latches the opcode at T3,
// sets sticky halt/fault flags, and muxes the decoded control word with
// the inactive word under reset, fault or halt. State changes on the
// falling clock edge, matching the ring counter.
// Optional: define SAP_INSTR_CNT_EN to add the saturating 8-bit
// completed-instruction counter on port icount.
module sap_controller
  import sap_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic [5:0]  t,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic        hlt,
  output logic        fault
`ifdef SAP_INSTR_CNT_EN
  ,
  output logic [7:0]  icount
`endif
);

  opcode_t op_q, op_d;
  logic    hlt_q, hlt_d;
  logic    fault_q, fault_d;
  con_t    dec_con;

  sap_con_decode u_decode (
    .t_i   (t),
    .op_i  (op_q),
    .con_o (dec_con)
  );

  // Next-state: opcode latch and halt at T3, fault on any non-one-hot T vector
  always_comb begin
    op_d    = op_q;
    hlt_d   = hlt_q;
    fault_d = fault_q;
    if (t == T3) begin
      op_d = opcode;
      if (opcode == OP_HLT) hlt_d = 1'b1;
    end
    if (!is_one_hot(t)) fault_d = 1'b1;
  end

  // State registers, falling-edge clocked with asynchronous active-low clear
  always_ff @(negedge clk or negedge res) begin
    if (!res) begin
      op_q    <= OP_LDA;
      hlt_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      op_q    <= op_d;
      hlt_q   <= hlt_d;
      fault_q <= fault_d;
    end
  end

  // Output override: reset > fault > halt > decoded word
  always_comb begin
    con = dec_con;
    if (!res)         con = NOP_CON;
    else if (fault_q) con = NOP_CON;
    else if (hlt_q)   con = NOP_CON;
  end

  assign hlt   = hlt_q;
  assign fault = fault_q;

`ifdef SAP_INSTR_CNT_EN
  logic [7:0] icount_q, icount_d;

  // Count instructions reaching T6 while running; saturate at 255
  always_comb begin
    icount_d = icount_q;
    if ((t == T6) && !hlt_q && !fault_q && (icount_q != 8'hFF))
      icount_d = icount_q + 8'd1;
  end

  // Counter register
  always_ff @(negedge clk or negedge res) begin
    if (!res) icount_q <= 8'd0;
    else      icount_q <= icount_d;
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: self-checking bench for sap_controller. A behavioural
// model (micro-op tables plus opcode/halt/fault/count state) predicts con,
// hlt, fault and, when SAP_INSTR_CNT_EN is defined, icount. Inputs change
// just after the rising edge; outputs are sampled before and after each
// falling (active) edge.
module tb_sap_controller;

  logic        clk;
  logic        res;
  logic [5:0]  t_r;
  logic [3:0]  opcode_r;
  logic [11:0] con;
  logic        hlt;
  logic        fault;
`ifdef SAP_INSTR_CNT_EN
  logic [7:0]  icount;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] m_op;
  bit         m_hlt;
  bit         m_fault;
  int         m_cnt;

  sap_controller dut (
    .clk    (clk),
    .res    (res),
    .t      (t_r),
    .opcode (opcode_r),
    .con    (con),
    .hlt    (hlt),
    .fault  (fault)
`ifdef SAP_INSTR_CNT_EN
    ,
    .icount (icount)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Execute-phase words per opcode, index 0..2 = T4..T6
  function automatic logic [11:0] exec_word(input logic [3:0] op, input int k);
    logic [11:0] w [3];
    case (op)
      4'b0000: w = '{12'h1A3, 12'h2C3, 12'h3E3};
      4'b0001: w = '{12'h1A3, 12'h2E1, 12'h3C7};
      4'b0010: w = '{12'h1A3, 12'h2E1, 12'h3CF};
      4'b1110: w = '{12'h3F2, 12'h3E3, 12'h3E3};
      default: w = '{12'h3E3, 12'h3E3, 12'h3E3};
    endcase
    return w[k];
  endfunction

  function automatic logic [11:0] model_con(input logic [5:0] tv);
    logic [11:0] fetch_w [3];
    int pos;
    fetch_w = '{12'h5E3, 12'hBE3, 12'h263};
    if (res !== 1'b1 || m_fault || m_hlt) return 12'h3E3;
    if ($countones(tv) != 1) return 12'h3E3;
    pos = 0;
    for (int i = 0; i < 6; i++) if (tv[5-i]) pos = i;
    if (pos < 3) return fetch_w[pos];
    return exec_word(m_op, pos - 3);
  endfunction

  // Model of one falling edge with res high
  function automatic void model_edge(input logic [5:0] tv, input logic [3:0] opc);
    if (tv == 6'b000001 && !m_hlt && !m_fault && m_cnt < 255) m_cnt++;
    if (tv == 6'b001000) begin
      m_op = opc;
      if (opc == 4'hF) m_hlt = 1'b1;
    end
    if ($countones(tv) != 1) m_fault = 1'b1;
  endfunction

  function automatic void model_reset();
    m_op    = 4'h0;
    m_hlt   = 1'b0;
    m_fault = 1'b0;
    m_cnt   = 0;
  endfunction

  task automatic check_state(input string tag);
    check($sformatf("%s hlt", tag), {11'b0, hlt}, {11'b0, m_hlt});
    check($sformatf("%s fault", tag), {11'b0, fault}, {11'b0, m_fault});
`ifdef SAP_INSTR_CNT_EN
    check($sformatf("%s icount", tag), {4'b0, icount}, 12'(m_cnt));
`endif
  endtask

  // Drive one T-state for a full clock and check around the falling edge
  task automatic step(input logic [5:0] tv, input logic [3:0] opc, input string tag);
    @(posedge clk);
    #1;
    t_r      = tv;
    opcode_r = opc;
    #1;
    check($sformatf("%s con", tag), con, model_con(tv));
    @(negedge clk);
    model_edge(tv, opc);
    #1;
    check($sformatf("%s con_post", tag), con, model_con(tv));
    check_state(tag);
  endtask

  // One instruction: op presented through T1-T3, late_op through T4-T6
  task automatic instr(input logic [3:0] op, input logic [3:0] late_op, input string tag);
    for (int k = 0; k < 6; k++)
      step(6'b100000 >> k, (k < 3) ? op : late_op, $sformatf("%s_t%0d", tag, k + 1));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    res      = 1'b0;
    t_r      = 6'b100000;
    opcode_r = 4'h0;
    #1;
    model_reset();
    check($sformatf("%s rst con", tag), con, 12'h3E3);
    check_state($sformatf("%s rst", tag));
    @(posedge clk);
    #1;
    res = 1'b1;
    #1;
    check($sformatf("%s rel con", tag), con, 12'h5E3);
    @(negedge clk);
    model_edge(t_r, opcode_r);
  endtask

  initial begin
    logic [11:0] lda_exp [6];
    logic [11:0] sub_exp [6];
    logic [3:0]  op_list [4];
    logic [3:0]  op;
    lda_exp = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3};
    sub_exp = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF};
    op_list = '{4'h0, 4'h1, 4'h2, 4'hE};

    res      = 1'b0;
    t_r      = 6'b100000;
    opcode_r = 4'h0;
    model_reset();

    // Reset state
    do_reset("init");

    // LDA fetch and execute against literal words
    for (int k = 0; k < 6; k++) begin
      step(6'b100000 >> k, 4'h0, $sformatf("lda_t%0d", k + 1));
      check($sformatf("lda_t%0d lit", k + 1), con, lda_exp[k]);
    end

    // SUB with opcode switched to OUT during T5: execute must stay SUB
    for (int k = 0; k < 6; k++) begin
      step(6'b100000 >> k, (k >= 4) ? 4'hE : 4'h2, $sformatf("sub_t%0d", k + 1));
      check($sformatf("sub_t%0d lit", k + 1), con, sub_exp[k]);
    end

    // Random instruction stream with noise on opcode during execute
    for (int n = 0; n < 40; n++) begin
      int r;
      r  = $urandom_range(0, 5);
      op = (r < 4) ? op_list[r] : 4'($urandom_range(3, 13));
      instr(op, 4'($urandom), $sformatf("rnd%0d", n));
    end

    // HLT: flag rises at T3 edge, control word inactive until reset
    instr(4'hF, 4'h0, "hlt");
    check("hlt flag lit", {11'b0, hlt}, 12'h001);
    instr(4'h0, 4'h0, "hlt_run1");
    instr(4'h1, 4'h1, "hlt_run2");
    check("hlt con lit", con, 12'h3E3);
    do_reset("hlt");
    check("hlt cleared lit", {11'b0, hlt}, 12'h000);

    // Fault on a two-hot T vector, sticky through normal T-states
    step(6'b100000, 4'h0, "flt_pre");
    step(6'b001100, 4'h0, "flt_bad");
    check("flt flag lit", {11'b0, fault}, 12'h001);
    check("flt con lit", con, 12'h3E3);
    step(6'b100000, 4'h0, "flt_t1");
    check("flt t1 con lit", con, 12'h3E3);
    instr(4'h1, 4'h1, "flt_run");
    do_reset("flt");

    // Fault on an all-zero T vector
    step(6'b000000, 4'h0, "flt_zero");
    check("flt zero flag lit", {11'b0, fault}, 12'h001);
    do_reset("flt_zero");

    // Reset during T5 of ADD: immediate inactive word, op_q cleared to LDA
    for (int k = 0; k < 5; k++)
      step(6'b100000 >> k, 4'h1, $sformatf("add_t%0d", k + 1));
    check("add_t5 lit", con, 12'h2E1);
    res = 1'b0;
    #1;
    model_reset();
    check("midrst con lit", con, 12'h3E3);
    check_state("midrst");
    #2;
    res = 1'b1;
    step(6'b000010, 4'h1, "midrst_t5");
    check("midrst op cleared lit", con, 12'h2C3);
    step(6'b000001, 4'h1, "midrst_t6");
    instr(4'h1, 4'h1, "post_rst_add");

`ifdef SAP_INSTR_CNT_EN
    // Counter saturation and HLT not counted
    do_reset("cnt");
    for (int n = 0; n < 260; n++) instr(4'h0, 4'h0, $sformatf("cnt%0d", n));
    check("icount sat lit", {4'b0, icount}, 12'd255);
    instr(4'hF, 4'h0, "cnt_hlt");
    check("icount after hlt lit", {4'b0, icount}, 12'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
